mem_stage_dmem: RTL and testbench



---
 rtl/mem_stage_dmem.sv | 89 ++++++++
 tb/tb_mem_stage_dmem.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mem_stage_dmem.sv
// rtl/mem_stage_dmem.sv - multi-cycle LDUR/STUR data-memory responder for the MEM stage
module mem_stage_dmem #(
   parameter int DEPTH   = 32,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memRead_M,
   input  logic        memWrite_M,
   input  logic [63:0] address_M,
   input  logic [63:0] writeData_M,
   output logic [63:0] readData_M,
   output logic        stall_M,
   output logic        misaligned_M
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   logic               req;
   logic               op_write_q;
   logic               misalign_q;
   logic [IDX_W-1:0]   idx_q;
   logic [63:0]        data_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [63:0]        mem [DEPTH];

   assign req = memRead_M | memWrite_M;

   // DONE never stalls, which is what lets the pipeline advance past the completed access
   assign stall_M = ~reset & ((req & (state != DONE)) | (state == BUSY));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         readData_M   <= '0;
         misaligned_M <= 1'b0;
         op_write_q   <= 1'b0;
         misalign_q   <= 1'b0;
         idx_q        <= '0;
         data_q       <= '0;
         cnt_q        <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  op_write_q <= memWrite_M;
                  misalign_q <= |address_M[2:0];
                  idx_q      <= address_M[IDX_W+2:3];
                  data_q     <= writeData_M;
                  cnt_q      <= CNT_W'(LATENCY - 1);
                  state      <= BUSY;
               end
            end
            BUSY: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  if (misalign_q) begin
                     readData_M   <= '0;
                     misaligned_M <= 1'b1;
                  end else if (op_write_q) begin
                     mem[idx_q] <= data_q;
                  end else begin
                     readData_M <= mem[idx_q];
                  end
                  state <= DONE;
               end
            end
            DONE: begin
               misaligned_M <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_dmem.sv
// tb/tb_mem_stage_dmem.sv - scoreboard bench for mem_stage_dmem
module tb_mem_stage_dmem;

   localparam int DEPTH   = 32;
   localparam int LATENCY = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        memRead_M;
   logic        memWrite_M;
   logic [63:0] address_M;
   logic [63:0] writeData_M;
   logic [63:0] readData_M;
   logic        stall_M;
   logic        misaligned_M;

   typedef struct {
      logic [63:0] rd;
      logic        mis;
   } exp_t;

   exp_t        sb [$];
   logic [63:0] model [DEPTH];
   logic [63:0] last_rd;
   int          checks = 0;
   int          errors = 0;

   mem_stage_dmem #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
      .clk         (clk),
      .reset       (reset),
      .memRead_M   (memRead_M),
      .memWrite_M  (memWrite_M),
      .address_M   (address_M),
      .writeData_M (writeData_M),
      .readData_M  (readData_M),
      .stall_M     (stall_M),
      .misaligned_M(misaligned_M)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      last_rd = '0;
   endtask

   task automatic access(input logic rd, input logic wr, input logic [63:0] addr,
                         input logic [63:0] data, input logic scramble, input string tag);
      exp_t e;
      int   n;
      logic [4:0] idx;
      idx = addr[7:3];
      if (|addr[2:0]) begin
         e.rd = '0; e.mis = 1'b1; last_rd = '0;
      end else if (wr) begin
         model[idx] = data; e.rd = last_rd; e.mis = 1'b0;
      end else begin
         e.rd = model[idx]; e.mis = 1'b0; last_rd = e.rd;
      end
      sb.push_back(e);

      @(posedge clk); #1;
      memRead_M = rd; memWrite_M = wr; address_M = addr; writeData_M = data;
      n = 0;
      @(negedge clk);
      while (stall_M === 1'b1 && n < 20) begin
         n++;
         if (scramble && n == 2) begin
            memRead_M = 1'b0; memWrite_M = 1'b0;
            address_M = ~addr; writeData_M = ~data;
         end
         @(negedge clk);
      end
      check({tag, "_stall_cycles"}, 64'(n), 64'(LATENCY + 1));
      e = sb.pop_front();
      check({tag, "_readData"}, readData_M, e.rd);
      check({tag, "_misaligned"}, 64'(misaligned_M), 64'(e.mis));

      @(posedge clk); #1;
      memRead_M = 1'b0; memWrite_M = 1'b0; address_M = '0; writeData_M = '0;
      @(negedge clk);
      check({tag, "_misaligned_clear"}, 64'(misaligned_M), 64'd0);
      check({tag, "_idle_stall"}, 64'(stall_M), 64'd0);
   endtask

   initial begin
      model_reset();
      reset = 1'b1;
      memRead_M = 1'b1; memWrite_M = 1'b0;
      address_M = 64'h10; writeData_M = '0;
      #12;
      check("reset_stall", 64'(stall_M), 64'd0);
      check("reset_readData", readData_M, 64'd0);
      check("reset_misaligned", 64'(misaligned_M), 64'd0);
      memRead_M = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      access(1'b0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 1'b0, "store_0x10");
      access(1'b1, 1'b0, 64'h10, 64'h0, 1'b0, "load_0x10");
      access(1'b1, 1'b0, 64'h13, 64'h0, 1'b0, "misaligned_load");
      access(1'b1, 1'b0, 64'h10, 64'h0, 1'b0, "reload_0x10");
      access(1'b0, 1'b1, 64'h100, 64'h1, 1'b0, "store_wrap");
      access(1'b1, 1'b0, 64'h0, 64'h0, 1'b0, "load_wrap");
      access(1'b1, 1'b1, 64'h8, 64'h55, 1'b0, "rd_wr_both");
      access(1'b1, 1'b0, 64'h8, 64'h0, 1'b1, "load_0x8_scrambled");
      access(1'b0, 1'b1, 64'h21, 64'h77, 1'b0, "misaligned_store");
      access(1'b1, 1'b0, 64'h20, 64'h0, 1'b0, "load_0x20");

      // abort a store while BUSY
      @(posedge clk); #1;
      memWrite_M = 1'b1; address_M = 64'h18; writeData_M = 64'hAA;
      @(posedge clk); #1;
      memWrite_M = 1'b0; address_M = '0; writeData_M = '0;
      reset = 1'b1;
      #1;
      check("midbusy_reset_stall", 64'(stall_M), 64'd0);
      check("midbusy_reset_readData", readData_M, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();

      access(1'b1, 1'b0, 64'h18, 64'h0, 1'b0, "load_after_abort");
      access(1'b1, 1'b0, 64'h10, 64'h0, 1'b0, "load_cleared_0x10");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
